// File: rtl/orion_mem_pkg.sv
// Shared types and constants for the Orion paging unit and memory-cycle sequencer.
package orion_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } mem_state_e;

    localparam logic [3:0] REG_WP   = 4'd8;
    localparam logic [3:0] REG_STAT = 4'd9;

    localparam int WCNT_W = 4;

endpackage

// File: rtl/orion_mapper_regs.sv
// I/O-mapped page, write-protect and fault registers with once-per-cycle write commit
// and combinational readback.
module orion_mapper_regs
    import orion_mem_pkg::*;
#(
    parameter int         WINDOWS = 4,
    parameter int         PAGE_W  = 8,
    parameter logic [7:0] IO_BASE = 8'h10,
    localparam int        WB      = $clog2(WINDOWS)
) (
    input  logic              i_clk,
    input  logic              reset_n,
    input  logic [7:0]        i_io_addr,
    input  logic [7:0]        i_wdata,
    input  logic              i_iorq_n,
    input  logic              i_mreq_n,
    input  logic              i_rd_n,
    input  logic              i_wr_n,
    input  logic [WB-1:0]     i_win,
    input  logic              i_fault_set,
    output logic [PAGE_W-1:0] o_page,
    output logic              o_wp_hit,
    output logic              o_fault,
    output logic [7:0]        o_rdata,
    output logic              o_rdata_oe
);

    logic [PAGE_W-1:0]  page_q [WINDOWS];
    logic [PAGE_W-1:0]  page_d [WINDOWS];
    logic [WINDOWS-1:0] wp_q;
    logic [WINDOWS-1:0] wp_d;
    logic               fault_q;
    logic               fault_d;
    logic               wr_done_q;
    logic               wr_done_d;

    logic               io_sel_s;
    logic               blk_hit_s;
    logic               page_hit_s;
    logic               wr_commit_s;
    logic [3:0]         off_s;

    // An I/O cycle that overlaps a memory request is ignored entirely
    assign io_sel_s    = !i_iorq_n && i_mreq_n;
    assign off_s       = i_io_addr[3:0];
    assign blk_hit_s   = (i_io_addr[7:4] == IO_BASE[7:4]);
    assign page_hit_s  = blk_hit_s && (off_s < 4'(WINDOWS));
    assign wr_commit_s = io_sel_s && !i_wr_n && !wr_done_q && blk_hit_s;

    assign o_page   = page_q[i_win];
    assign o_wp_hit = wp_q[i_win];
    assign o_fault  = fault_q;

    // Next-state for the register file and the write-once latch
    always_comb begin
        page_d    = page_q;
        wp_d      = wp_q;
        fault_d   = fault_q;
        wr_done_d = wr_done_q;

        if (i_iorq_n) begin
            wr_done_d = 1'b0;
        end else if (io_sel_s && !i_wr_n) begin
            wr_done_d = 1'b1;
        end else begin
            wr_done_d = wr_done_q;
        end

        if (wr_commit_s && page_hit_s) begin
            page_d[off_s[WB-1:0]] = PAGE_W'(i_wdata);
        end else begin
            page_d = page_q;
        end

        if (wr_commit_s && (off_s == REG_WP)) begin
            wp_d = i_wdata[WINDOWS-1:0];
        end else begin
            wp_d = wp_q;
        end

        // A new violation on the same edge as a software clear must not be lost
        if (i_fault_set) begin
            fault_d = 1'b1;
        end else if (wr_commit_s && (off_s == REG_STAT) && i_wdata[0]) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // Register file state with synchronous reset to identity paging
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            for (int n = 0; n < WINDOWS; n++) begin
                page_q[n] <= PAGE_W'(n);
            end
            wp_q      <= '0;
            fault_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            page_q    <= page_d;
            wp_q      <= wp_d;
            fault_q   <= fault_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Readback mux; unmapped offsets leave the bus undriven
    always_comb begin
        o_rdata    = 8'h00;
        o_rdata_oe = 1'b0;
        if (io_sel_s && !i_rd_n && blk_hit_s) begin
            if (page_hit_s) begin
                o_rdata    = 8'(page_q[off_s[WB-1:0]]);
                o_rdata_oe = 1'b1;
            end else if (off_s == REG_WP) begin
                o_rdata    = 8'(wp_q);
                o_rdata_oe = 1'b1;
            end else if (off_s == REG_STAT) begin
                o_rdata    = {7'd0, fault_q};
                o_rdata_oe = 1'b1;
            end else begin
                o_rdata    = 8'h00;
                o_rdata_oe = 1'b0;
            end
        end else begin
            o_rdata    = 8'h00;
            o_rdata_oe = 1'b0;
        end
    end

endmodule

// File: rtl/orion_mem_mapper.sv
// Orion paging unit: window-to-page address translation plus a wait-state
// sequencer that stretches CPU memory cycles onto the physical SRAM bus.
module orion_mem_mapper
    import orion_mem_pkg::*;
#(
    parameter int         WINDOWS     = 4,
    parameter int         PAGE_W      = 8,
    parameter int         PHYS_AW     = PAGE_W + 16 - $clog2(WINDOWS),
    parameter logic [7:0] IO_BASE     = 8'h10,
    parameter int         WAIT_STATES = 2
) (
    input  logic               i_clk,
    input  logic               reset_n,
    input  logic [15:0]        i_addr,
    input  logic [7:0]         i_wdata,
    input  logic               i_mreq_n,
    input  logic               i_iorq_n,
    input  logic               i_rd_n,
    input  logic               i_wr_n,
    input  logic               i_rfsh_n,
    output logic [7:0]         o_rdata,
    output logic               o_rdata_oe,
    output logic               o_wait_n,
    output logic [PHYS_AW-1:0] o_mem_addr,
    output logic [7:0]         o_mem_wdata,
    output logic               o_mem_we,
    output logic               o_mem_re,
    input  logic [7:0]         i_mem_rdata,
    output logic               o_fault
);

    localparam int WB    = $clog2(WINDOWS);
    localparam int OFF_W = 16 - WB;

    mem_state_e         state_q, state_d;
    logic [WCNT_W-1:0]  cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [PHYS_AW-1:0] addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               re_q, re_d;
    logic               we_q, we_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               mem_req_s;
    logic               fault_set_s;
    logic               wp_hit_s;
    logic               hold_rd_s;
    logic [PAGE_W-1:0]  page_s;
    logic [PHYS_AW-1:0] phys_s;
    logic [7:0]         io_rdata_s;
    logic               io_oe_s;

    orion_mapper_regs #(
        .WINDOWS (WINDOWS),
        .PAGE_W  (PAGE_W),
        .IO_BASE (IO_BASE)
    ) u_regs (
        .i_clk       (i_clk),
        .reset_n     (reset_n),
        .i_io_addr   (i_addr[7:0]),
        .i_wdata     (i_wdata),
        .i_iorq_n    (i_iorq_n),
        .i_mreq_n    (i_mreq_n),
        .i_rd_n      (i_rd_n),
        .i_wr_n      (i_wr_n),
        .i_win       (i_addr[15 -: WB]),
        .i_fault_set (fault_set_s),
        .o_page      (page_s),
        .o_wp_hit    (wp_hit_s),
        .o_fault     (o_fault),
        .o_rdata     (io_rdata_s),
        .o_rdata_oe  (io_oe_s)
    );

    // Refresh and I/O-overlapped cycles never start a memory access
    assign mem_req_s = !i_mreq_n && i_iorq_n && i_rfsh_n && (!i_rd_n || !i_wr_n);
    assign phys_s    = PHYS_AW'({page_s, i_addr[OFF_W-1:0]});
    assign hold_rd_s = (state_q == ST_HOLD) && !wr_q;

    assign o_wait_n    = !(mem_req_s && (state_q != ST_HOLD));
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_we    = we_q;
    assign o_mem_re    = re_q;
    assign o_rdata     = hold_rd_s ? rdata_q : io_rdata_s;
    assign o_rdata_oe  = hold_rd_s || io_oe_s;

    // Memory-cycle sequencer next-state and strobe generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        re_d        = re_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        fault_set_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_s) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = WCNT_W'(WAIT_STATES);
                    wr_d        = !i_wr_n;
                    addr_d      = phys_s;
                    wdata_d     = i_wdata;
                    re_d        = i_wr_n;
                    we_d        = !i_wr_n && !wp_hit_s;
                    fault_set_s = !i_wr_n && wp_hit_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == WCNT_W'(0)) begin
                    state_d = ST_HOLD;
                    rdata_d = i_mem_rdata;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (i_mreq_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered memory-bus outputs
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= WCNT_W'(0);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_orion_mem_mapper.sv
// Directed bench for orion_mem_mapper: a WAIT_STATES=2 instance for the main
// scenarios and a WAIT_STATES=0 instance for the single-wait build.
module tb_orion_mem_mapper;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]  mem_rdata;

    logic [7:0]  rdata1, rdata2;
    logic        oe1, oe2, wait1, wait2, we1, we2, re1, re2, fault1, fault2;
    logic [21:0] maddr1, maddr2;
    logic [7:0]  mwdata1, mwdata2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    orion_mem_mapper #(.WAIT_STATES(2)) dut (
        .i_clk(clk), .reset_n(reset_n), .i_addr(addr), .i_wdata(wdata),
        .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
        .i_rfsh_n(rfsh_n), .o_rdata(rdata1), .o_rdata_oe(oe1), .o_wait_n(wait1),
        .o_mem_addr(maddr1), .o_mem_wdata(mwdata1), .o_mem_we(we1), .o_mem_re(re1),
        .i_mem_rdata(mem_rdata), .o_fault(fault1)
    );

    orion_mem_mapper #(.WAIT_STATES(0)) dut_ws0 (
        .i_clk(clk), .reset_n(reset_n), .i_addr(addr), .i_wdata(wdata),
        .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
        .i_rfsh_n(rfsh_n), .o_rdata(rdata2), .o_rdata_oe(oe2), .o_wait_n(wait2),
        .o_mem_addr(maddr2), .o_mem_wdata(mwdata2), .o_mem_we(we2), .o_mem_re(re2),
        .i_mem_rdata(mem_rdata), .o_fault(fault2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr = {8'h00, a}; wdata = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        addr = {8'h00, a}; iorq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        d = rdata1; oe = oe1;
        tick();
        iorq_n = 1'b1; rd_n = 1'b1;
        tick();
    endtask

    // One CPU memory cycle on the WAIT_STATES=2 instance, with cycle counts
    task automatic mem_cycle(input logic [15:0] a, input logic is_wr, input logic [7:0] d,
                             output int re_c, output int we_c, output int wt_c,
                             output logic [21:0] ma, output logic [7:0] md,
                             output logic [7:0] rd, output logic oe, output logic idle_wait);
        logic done;
        re_c = 0; we_c = 0; wt_c = 0; done = 1'b0; ma = '0; md = 8'h00;
        addr = a; wdata = d; mreq_n = 1'b0; rd_n = is_wr; wr_n = !is_wr;
        @(negedge clk);
        idle_wait = wait1;
        tick();
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ma = maddr1; md = mwdata1;
            end
            if (re1) re_c++;
            if (we1) we_c++;
            if (wait1) done = 1'b1;
            else wt_c++;
        end
        rd = rdata1; oe = oe1;
        check_eq("mem_wait_release", {31'd0, done}, 32'd1);
        tick();
        mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int re_c, we_c, wt_c, lows;
        logic [21:0] ma;
        logic [7:0]  md, rd;
        logic        oe, iw, done;

        reset_n = 1'b0; addr = 16'h0000; wdata = 8'h00; mem_rdata = 8'h00;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_we", {31'd0, we1}, 32'd0);
        check_eq("rst_re", {31'd0, re1}, 32'd0);
        check_eq("rst_addr", {10'd0, maddr1}, 32'd0);
        check_eq("rst_wdata", {24'd0, mwdata1}, 32'd0);
        check_eq("rst_wait", {31'd0, wait1}, 32'd1);
        check_eq("rst_oe", {31'd0, oe1}, 32'd0);
        check_eq("rst_fault", {31'd0, fault1}, 32'd0);
        check_eq("rst_ws0_strobes", {30'd0, we2, re2}, 32'd0);
        check_eq("rst_ws0_bus", {2'd0, maddr2, mwdata2}, 32'd0);
        check_eq("rst_ws0_misc", {29'd0, wait2, oe2, fault2}, 32'd4);
        tick();
        io_read(8'h12, rd, oe);
        check_eq("rst_page2", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h02});

        // Read at reset mapping
        mem_rdata = 8'h5A;
        mem_cycle(16'h4000, 1'b0, 8'h00, re_c, we_c, wt_c, ma, md, rd, oe, iw);
        check_eq("rd_idle_wait", {31'd0, iw}, 32'd0);
        check_eq("rd_addr", {10'd0, ma}, 32'h04000);
        check_eq("rd_re_cycles", re_c, 32'd3);
        check_eq("rd_we_cycles", we_c, 32'd0);
        check_eq("rd_wait_cycles", wt_c, 32'd3);
        check_eq("rd_data", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h5A});

        // Remapped write
        io_write(8'h11, 8'h2A);
        io_read(8'h11, rd, oe);
        check_eq("page1_readback", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h2A});
        mem_cycle(16'h4123, 1'b1, 8'h55, re_c, we_c, wt_c, ma, md, rd, oe, iw);
        check_eq("wr_addr", {10'd0, ma}, 32'hA8123);
        check_eq("wr_wdata", {24'd0, md}, 32'h55);
        check_eq("wr_we_cycles", we_c, 32'd3);
        check_eq("wr_re_cycles", re_c, 32'd0);
        check_eq("wr_hold_oe", {31'd0, oe}, 32'd0);
        check_eq("wr_no_fault", {31'd0, fault1}, 32'd0);

        // Write protection and sticky fault
        io_write(8'h18, 8'h02);
        io_read(8'h18, rd, oe);
        check_eq("wp_readback", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h02});
        mem_cycle(16'h4000, 1'b1, 8'h77, re_c, we_c, wt_c, ma, md, rd, oe, iw);
        check_eq("wp_we_cycles", we_c, 32'd0);
        check_eq("wp_wait_cycles", wt_c, 32'd3);
        check_eq("wp_fault", {31'd0, fault1}, 32'd1);
        io_read(8'h19, rd, oe);
        check_eq("wp_status", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h01});
        mem_cycle(16'h8000, 1'b1, 8'h66, re_c, we_c, wt_c, ma, md, rd, oe, iw);
        check_eq("wp_other_we", we_c, 32'd3);
        check_eq("wp_other_addr", {10'd0, ma}, 32'h08000);
        check_eq("fault_sticky", {31'd0, fault1}, 32'd1);
        io_write(8'h19, 8'h01);
        check_eq("fault_clear", {31'd0, fault1}, 32'd0);
        io_read(8'h19, rd, oe);
        check_eq("status_clear", {23'd0, oe, rd}, {23'd0, 1'b1, 8'h00});

        // Held I/O write commits only the first cycle's data
        addr = 16'h0010; iorq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata = 8'h11 * 8'(i + 1);
            tick();
        end
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        io_read(8'h10, rd, oe);
        check_eq("io_write_once", {24'd0, rd}, 32'h11);
        mem_rdata = 8'hA5;
        mem_cycle(16'h0000, 1'b0, 8'h00, re_c, we_c, wt_c, ma, md, rd, oe, iw);
        check_eq("page0_addr", {10'd0, ma}, 32'h44000);
        check_eq("page0_data", {24'd0, rd}, 32'hA5);

        // Refresh cycle is ignored
        addr = 16'h4000; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; lows = 0;
        repeat (4) begin
            @(negedge clk);
            if (!wait1 || re1 || we1 || oe1) lows++;
        end
        tick();
        mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1;
        tick();
        check_eq("refresh_quiet", lows, 32'd0);

        // Unmapped I/O reads
        io_read(8'h1A, rd, oe);
        check_eq("unmapped_1a_oe", {31'd0, oe}, 32'd0);
        io_read(8'h14, rd, oe);
        check_eq("unmapped_14_oe", {31'd0, oe}, 32'd0);
        io_read(8'h20, rd, oe);
        check_eq("unmapped_20_oe", {31'd0, oe}, 32'd0);

        // MREQ and IORQ together: nothing happens
        addr = 16'h0010; wdata = 8'h99; mreq_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        check_eq("both_low_wait", {31'd0, wait1}, 32'd1);
        tick();
        @(negedge clk);
        check_eq("both_low_strobes", {30'd0, re1, we1}, 32'd0);
        tick();
        mreq_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        io_read(8'h10, rd, oe);
        check_eq("both_low_page", {24'd0, rd}, 32'h11);

        // Reset during ACCESS
        addr = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        @(negedge clk);
        check_eq("mid_re_active", {31'd0, re1}, 32'd1);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_strobes", {30'd0, re1, we1}, 32'd0);
        check_eq("mid_rst_addr", {10'd0, maddr1}, 32'd0);
        check_eq("mid_rst_oe", {31'd0, oe1}, 32'd0);
        mreq_n = 1'b1; rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        // Single-wait build
        mem_rdata = 8'hC3; addr = 16'h8004; mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        wt_c = 0; done = 1'b0; ma = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0) ma = maddr2;
            if (wait2) done = 1'b1;
            else wt_c++;
        end
        check_eq("ws0_release", {31'd0, done}, 32'd1);
        mem_rdata = 8'h3C;
        #1;
        check_eq("ws0_wait_cycles", wt_c, 32'd1);
        check_eq("ws0_addr", {10'd0, ma}, 32'h08004);
        check_eq("ws0_data", {23'd0, oe2, rdata2}, {23'd0, 1'b1, 8'hC3});
        tick();
        mreq_n = 1'b1; rd_n = 1'b1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/orion_mem_mapper.md
# orion_mem_mapper

Parametrised paging unit and memory-cycle sequencer for the Orion CPU bus. Splits the 64 KiB CPU space into `WINDOWS` equal windows, each mapped through an I/O-programmable page register onto a wide physical SRAM address. It also provides per-window write protection with a sticky fault flag. Accesses to slow external memory are stretched by a wait-state FSM. The block sits between the tv80 core and the board RAM, replacing fixed page decode in the top level.

## Interface
- `WINDOWS`, 4: number of windows; power of two, 2..8; `WB = $clog2(WINDOWS)`.
- `PAGE_W`, 8: page register width.
- `PHYS_AW`, `PAGE_W+16-WB`: physical address width.
- `IO_BASE`, 8'h10: register block base; multiple of 16.
- `WAIT_STATES`, 2: wait cycles per memory access, 0..15.

Ports:
- `i_clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `i_addr` in 16: CPU address.
- `i_wdata` in 8: CPU write data.
- `i_mreq_n`, `i_iorq_n`, `i_rd_n`, `i_wr_n`, `i_rfsh_n` in 1 each: CPU strobes.
- `o_rdata` out 8: read data to CPU.
- `o_rdata_oe` out 1: `o_rdata` valid; the top level muxes on it.
- `o_wait_n` out 1: CPU wait.
- `o_mem_addr` out PHYS_AW: physical address, registered.
- `o_mem_wdata` out 8: registered write data.
- `o_mem_we`, `o_mem_re` out 1: memory strobes, registered.
- `i_mem_rdata` in 8: memory read data.
- `o_fault` out 1: sticky write-protect violation.

## Operation
- Window index is `w = i_addr[15:16-WB]`. Physical address is `{page[w], i_addr[15-WB:0]}`.
- I/O registers, decoded on `i_addr[7:0]` with `i_iorq_n`=0:
  - `IO_BASE+n` (n<WINDOWS): `page[n]`, read/write.
  - `IO_BASE+8`: `wp[WINDOWS-1:0]` write-protect mask, read/write; unused bits read 0.
  - `IO_BASE+9`: status. Bit0 = fault. Writing 1 to bit0 clears it; read returns `{7'b0, fault}`.
- I/O write commits once per `i_iorq_n` low period: on the first edge where `i_iorq_n`=0 and `i_wr_n`=0. A latch flag blocks repeats until `i_iorq_n` returns high.
- I/O read: `o_rdata_oe`=1 combinationally while a mapped register is addressed with `i_rd_n`=0. Unmapped I/O gives `o_rdata_oe`=0.
- Memory FSM states:
  - IDLE → ACCESS when `i_mreq_n`=0, `i_rfsh_n`=1, and (`i_rd_n`=0 or `i_wr_n`=0). On that transition, latch address, data and direction, and load counter = WAIT_STATES.
  - ACCESS: assert `o_mem_re` or `o_mem_we`; counter decrements each cycle. At counter 0, capture `i_mem_rdata` into the read register and move to HOLD.
  - HOLD → IDLE when `i_mreq_n`=1.
- Write to a window with `wp[w]`=1:
  - `o_mem_we` stays 0; fault sets at the ACCESS entry edge.
  - The cycle otherwise completes normally.
- Refresh cycles (`i_rfsh_n`=0) are ignored. `i_mreq_n` and `i_iorq_n` both low: no action.
- Memory read: `o_rdata_oe`=1 in HOLD when the latched direction is read.

## Timing
- Reset values:
  - `page[n]=n`, `wp=0`, `fault=0`, FSM=IDLE.
  - `o_mem_we`=`o_mem_re`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
  - `o_wait_n`=1, `o_rdata_oe`=0.
- `o_wait_n` is combinational: 0 when a qualifying memory request is present and the FSM is IDLE or ACCESS.
- Memory access latency: detection edge, then WAIT_STATES+1 cycles in ACCESS. Read data is valid and `o_wait_n` is 1 from the first HOLD cycle.
  - WAIT_STATES=0 gives exactly one wait cycle.
- Page register writes take effect at the next memory request. An access in flight keeps its latched address.
- Reset mid-access: FSM goes to IDLE and strobes drop at that same edge. The aborted write is not guaranteed to have landed.
- Fault set and status clear on the same edge: set wins.

## Structure
- Package `orion_mem_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ACCESS`, `ST_HOLD`);
  - register offset constants (`REG_WP`=8, `REG_STAT`=9);
  - the 4-bit wait-counter width constant.
- Sub-module `orion_mapper_regs` holds the page, wp and fault registers, I/O decode, the write-once latch and the readback mux. The top of this block holds the address translation and the FSM.

## Test plan
- After reset, read from 0x4000, WINDOWS=4 → `o_mem_addr`=0x04000, `o_mem_re` high for 3 cycles, `o_wait_n` low for 3 cycles.
- OUT 0x11←0x2A; write 0x55 to 0x4123 → `o_mem_addr`=0xA8123, `o_mem_we` pulse of WAIT_STATES+1 cycles, `o_mem_wdata`=0x55.
- OUT 0x18←0x02; write to 0x4000 → no `o_mem_we`, `o_fault`=1, IN 0x19=0x01. OUT 0x19←0x01 → fault cleared.
- `i_iorq_n` held low for 4 cycles with `i_wr_n`=0 to 0x10 while `i_wdata` changes each cycle → only the first-cycle value is stored.
- Refresh cycle (`i_mreq_n`=0, `i_rfsh_n`=0) → no strobes, `o_wait_n`=1. Reset asserted mid-ACCESS → strobes 0 and FSM IDLE on the next edge.
- WAIT_STATES=0 build: read → exactly one wait cycle, data equals `i_mem_rdata` sampled at the ACCESS edge.
